title_renderer: RTL and testbench
=================================

# title_renderer

Parametrised, animated bitmap-text renderer for the VGA title screen. It maps the current raster position (DrawX, DrawY) onto a BMP_W × BMP_H multi-bit glyph bitmap, scaled by 2^SCALE_LOG2. The bitmap is read one row at a time from an external combinational row ROM. The text slides down into place, then blinks. The color mapper consumes pixel_on and pixel_idx; the game-state FSM drives start.

## Interface
- BMP_W, 89, bitmap width in source pixels
- BMP_H, 12, bitmap height in source pixels
- BPP, 2, bits per source pixel; code 0 is transparent
- SCALE_LOG2, 2, on-screen magnification is 2^SCALE_LOG2 per axis
- X_POS, 142, left edge of the bitmap on screen (10-bit)
- Y_FINAL, 200, resting top edge after the slide (10-bit)
- SLIDE_STEP, 4, screen lines moved per frame while sliding
- BLINK_FRAMES, 30, frames per blink half-period
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_clk  in  1  vertical-sync-rate level; each rising edge is one frame tick
- start  in  1  single-cycle request to begin the animation; honoured only in IDLE
- DrawX  in  10  current raster column
- DrawY  in  10  current raster row
- rom_row_addr  out  $clog2(BMP_H)  bitmap row to read
- rom_row_data  in  BMP_W*BPP  row contents, combinational from rom_row_addr; column 0 is at the MSBs
- pixel_on  out  1  draw the title colour at this pixel
- pixel_idx  out  BPP  palette index of this pixel
- done  out  1  high while in SHOW (slide complete)

## Operation
- Frame tick: frame_clk is registered once; tick = frame_clk & ~frame_clk_q.
- States:
  - IDLE: nothing is drawn. On start, go to SLIDE and set y_cur = 0.
  - SLIDE: on each tick, y_cur += SLIDE_STEP. When the sum is ≥ Y_FINAL, set y_cur = Y_FINAL and go to SHOW on the same tick.
  - SHOW: on each tick, blink_cnt increments. When blink_cnt reaches BLINK_FRAMES−1, it clears to 0 and visible toggles. The block stays in SHOW until Reset.
- visible is 1 on entry to SLIDE and on entry to SHOW; blink_cnt is 0 on entry to SHOW.
- start outside IDLE is ignored.
- Hit test, using the box width W = BMP_W<<SCALE_LOG2 and height H = BMP_H<<SCALE_LOG2:
  - hit requires X_POS ≤ DrawX < X_POS+W and y_cur ≤ DrawY < y_cur+H.
  - All comparisons use 11-bit unsigned arithmetic so that X_POS+W never wraps.
- Coordinates inside the box: col = (DrawX−X_POS)>>SCALE_LOG2 and row = (DrawY−y_cur)>>SCALE_LOG2.
- Pixel select: pixel_idx = rom_row_data[(BMP_W−1−col)*BPP +: BPP].
- Output gating: pixel_on = hit & visible & (state≠IDLE) & (pixel_idx≠0). When pixel_on is 0, pixel_idx is forced to 0.
- A tick and start arriving in the same cycle in IDLE: the block enters SLIDE, and that tick does not advance y_cur.
- Reset in any state returns to IDLE on the next edge, with no residual output after the pipeline flushes (the reset values below).

## Timing
- Pipeline stage 1 (registered): hit, row, col and the gating flags. rom_row_addr = row_q, driven directly from the register.
- Pipeline stage 2 (registered): pixel_idx and pixel_on.
- Latency: DrawX/DrawY at edge N produce pixel_on/pixel_idx valid after edge N+2. The colour mapper delays its own coordinates to match.
- Throughput: one pixel per clock with no stalls.
- y_cur and visible change only on ticks; a change reaches the outputs two cycles later.
- Reset values: pixel_on=0, pixel_idx=0, rom_row_addr=0, done=0, state=IDLE, y_cur=0, visible=1, blink_cnt=0, frame_clk_q=0.

## Structure
- A shared package title_pkg holds:
  - the state enum title_state_t {IDLE, SLIDE, SHOW}
  - the default geometry constants
  - the function bmp_sel(row_data, col)
- Sub-module title_frame_fsm (tick detect, state, y_cur, blink_cnt, visible, done). The pixel pipeline stays in the top module.
- The bitmap ROM is an external combinational module, so the same renderer serves title, game-over and score text.

## Test plan
- Reset then idle: drive 1000 cycles of raster, with and without ticks → pixel_on never 1, done=0.
- Slide: start, then 50 ticks → y_cur follows 0,4,…,196,200. done rises on tick 50 and y_cur stays at 200 afterwards.
- Pixel mapping in SHOW: DrawX=146, DrawY=204 (col 1, row 1, bitmap value 1) → after 2 cycles pixel_on=1, pixel_idx=1, rom_row_addr=1. DrawX=142, DrawY=204 (value 0) → pixel_on=0.
- Box edges in SHOW:
  - DrawX=497 (last column, 142+356−1) → in box.
  - DrawX=498 → pixel_on=0.
  - DrawY=247 → row 11; DrawY=248 → pixel_on=0.
- Blink: 30 ticks in SHOW → visible=0 and no pixels for the next 30 ticks; tick 60 → pixels return.
- Corner events:
  - start during SLIDE → ignored.
  - start coincident with a tick → y_cur still 0 after that edge.
  - Reset mid-SLIDE → IDLE, pixel_on=0 within 2 cycles.
  - A new start afterwards → restarts from y_cur=0.

Source files
------------

// File: rtl/title_pkg.sv
// Shared types, default geometry and bitmap pixel-select helper for the title renderer.
package title_pkg;

  typedef enum logic [1:0] {IDLE, SLIDE, SHOW} title_state_t;

  localparam int unsigned DEF_BMP_W        = 89;
  localparam int unsigned DEF_BMP_H        = 12;
  localparam int unsigned DEF_BPP          = 2;
  localparam int unsigned DEF_SCALE_LOG2   = 2;
  localparam int unsigned DEF_X_POS        = 142;
  localparam int unsigned DEF_Y_FINAL      = 200;
  localparam int unsigned DEF_SLIDE_STEP   = 4;
  localparam int unsigned DEF_BLINK_FRAMES = 30;

  localparam int unsigned COORD_W     = 10;
  localparam int unsigned CMP_W       = 11;
  localparam int unsigned SEL_ROW_MAX = 1024;
  localparam int unsigned SEL_BPP_MAX = 8;

  // Column 0 sits at the MSBs of the row word.
  function automatic logic [SEL_BPP_MAX-1:0] bmp_sel(
    input logic [SEL_ROW_MAX-1:0] row_data,
    input int unsigned            col,
    input int unsigned            bmp_w,
    input int unsigned            bpp
  );
    logic [SEL_ROW_MAX-1:0] shifted;
    logic [SEL_BPP_MAX-1:0] mask;
    shifted = row_data >> ((bmp_w - 1 - col) * bpp);
    mask    = SEL_BPP_MAX'((32'd1 << bpp) - 32'd1);
    return shifted[SEL_BPP_MAX-1:0] & mask;
  endfunction

endpackage

// File: rtl/title_frame_fsm.sv
// Frame-rate animation control: tick detect, slide-in position, blink phase.
module title_frame_fsm
  import title_pkg::*;
#(
  parameter int unsigned Y_FINAL      = DEF_Y_FINAL,
  parameter int unsigned SLIDE_STEP   = DEF_SLIDE_STEP,
  parameter int unsigned BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               frame_clk_i,
  input  logic               start_i,
  output logic [COORD_W-1:0] y_cur_o,
  output logic               visible_o,
  output logic               active_o,
  output logic               done_o
);

  localparam int unsigned BLINK_W = $clog2(BLINK_FRAMES + 1);

  title_state_t       state_q;
  logic               frame_clk_q;
  logic [COORD_W-1:0] y_cur_q;
  logic [BLINK_W-1:0] blink_cnt_q;
  logic               visible_q;
  logic               active_q;
  logic               done_q;

  logic               tick;
  logic [CMP_W-1:0]   slide_sum;

  assign tick      = frame_clk_i & ~frame_clk_q;
  assign slide_sum = CMP_W'(y_cur_q) + CMP_W'(SLIDE_STEP);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      frame_clk_q <= 1'b0;
      y_cur_q     <= '0;
      blink_cnt_q <= '0;
      visible_q   <= 1'b1;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      frame_clk_q <= frame_clk_i;
      case (state_q)
        IDLE: begin
          // A tick coinciding with start is consumed by the IDLE->SLIDE move.
          if (start_i) begin
            state_q   <= SLIDE;
            y_cur_q   <= '0;
            visible_q <= 1'b1;
            active_q  <= 1'b1;
          end
        end
        SLIDE: begin
          if (tick) begin
            if (slide_sum >= CMP_W'(Y_FINAL)) begin
              state_q     <= SHOW;
              y_cur_q     <= COORD_W'(Y_FINAL);
              visible_q   <= 1'b1;
              blink_cnt_q <= '0;
              done_q      <= 1'b1;
            end else begin
              y_cur_q <= COORD_W'(slide_sum);
            end
          end
        end
        SHOW: begin
          if (tick) begin
            if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
              blink_cnt_q <= '0;
              visible_q   <= ~visible_q;
            end else begin
              blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign y_cur_o   = y_cur_q;
  assign visible_o = visible_q;
  assign active_o  = active_q;
  assign done_o    = done_q;

endmodule

// File: rtl/title_renderer.sv
// Animated bitmap-text renderer: two-stage pixel pipeline over an external row ROM.
module title_renderer
  import title_pkg::*;
#(
  parameter int unsigned BMP_W        = DEF_BMP_W,
  parameter int unsigned BMP_H        = DEF_BMP_H,
  parameter int unsigned BPP          = DEF_BPP,
  parameter int unsigned SCALE_LOG2   = DEF_SCALE_LOG2,
  parameter int unsigned X_POS        = DEF_X_POS,
  parameter int unsigned Y_FINAL      = DEF_Y_FINAL,
  parameter int unsigned SLIDE_STEP   = DEF_SLIDE_STEP,
  parameter int unsigned BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     frame_clk,
  input  logic                     start,
  input  logic [COORD_W-1:0]       DrawX,
  input  logic [COORD_W-1:0]       DrawY,
  output logic [$clog2(BMP_H)-1:0] rom_row_addr,
  input  logic [BMP_W*BPP-1:0]     rom_row_data,
  output logic                     pixel_on,
  output logic [BPP-1:0]           pixel_idx,
  output logic                     done
);

  localparam int unsigned ROW_W = $clog2(BMP_H);
  localparam int unsigned COL_W = $clog2(BMP_W);
  localparam int unsigned BOX_W = BMP_W << SCALE_LOG2;
  localparam int unsigned BOX_H = BMP_H << SCALE_LOG2;

  logic [COORD_W-1:0] y_cur;
  logic               visible;
  logic               active;

  title_frame_fsm #(
    .Y_FINAL      (Y_FINAL),
    .SLIDE_STEP   (SLIDE_STEP),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_fsm (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .frame_clk_i (frame_clk),
    .start_i     (start),
    .y_cur_o     (y_cur),
    .visible_o   (visible),
    .active_o    (active),
    .done_o      (done)
  );

  // Stage 1: box hit test and bitmap coordinates, 11-bit so the box end never wraps.
  logic [CMP_W-1:0] dx, dy, y_top, x_end, y_end, x_off, y_off;
  logic             hit_d;
  logic [ROW_W-1:0] row_d;
  logic [COL_W-1:0] col_d;

  always_comb begin
    dx    = CMP_W'(DrawX);
    dy    = CMP_W'(DrawY);
    y_top = CMP_W'(y_cur);
    x_end = CMP_W'(X_POS + BOX_W);
    y_end = y_top + CMP_W'(BOX_H);
    x_off = dx - CMP_W'(X_POS);
    y_off = dy - y_top;
    hit_d = (dx >= CMP_W'(X_POS)) && (dx < x_end) && (dy >= y_top) && (dy < y_end);
    row_d = hit_d ? ROW_W'(y_off >> SCALE_LOG2) : '0;
    col_d = hit_d ? COL_W'(x_off >> SCALE_LOG2) : '0;
  end

  logic             hit_q;
  logic             gate_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hit_q  <= 1'b0;
      gate_q <= 1'b0;
      row_q  <= '0;
      col_q  <= '0;
    end else begin
      hit_q  <= hit_d;
      gate_q <= visible & active;
      row_q  <= row_d;
      col_q  <= col_d;
    end
  end

  assign rom_row_addr = row_q;

  // Stage 2: select the pixel from the ROM row and gate transparent/hidden pixels.
  logic [BPP-1:0] idx_sel;
  logic           pixel_on_d;
  logic [BPP-1:0] pixel_idx_d;

  always_comb begin
    idx_sel     = BPP'(bmp_sel(SEL_ROW_MAX'(rom_row_data), 32'(col_q), BMP_W, BPP));
    pixel_on_d  = hit_q & gate_q & (idx_sel != '0);
    pixel_idx_d = pixel_on_d ? idx_sel : '0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pixel_on  <= 1'b0;
      pixel_idx <= '0;
    end else begin
      pixel_on  <= pixel_on_d;
      pixel_idx <= pixel_idx_d;
    end
  end

endmodule

// File: tb/tb_title_renderer.sv
// Scoreboard bench for title_renderer: directed probes, expectations queued, monitor compares.
module tb_title_renderer;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         frame_clk = 1'b0;
  logic         start = 1'b0;
  logic [9:0]   DrawX = '0;
  logic [9:0]   DrawY = '0;
  logic [3:0]   rom_row_addr;
  logic [177:0] rom_row_data;
  logic         pixel_on;
  logic [1:0]   pixel_idx;
  logic         done;

  title_renderer dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .start        (start),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .rom_row_addr (rom_row_addr),
    .rom_row_data (rom_row_data),
    .pixel_on     (pixel_on),
    .pixel_idx    (pixel_idx),
    .done         (done)
  );

  always #5 Clk = ~Clk;

  // Test bitmap: value(row, col) = (col + row + 3) mod 4, column 0 at the MSBs.
  always_comb begin
    rom_row_data = '0;
    for (int c = 0; c < 89; c++)
      rom_row_data[(88 - c) * 2 +: 2] = 2'((c + int'(rom_row_addr) + 3) % 4);
  end

  typedef struct {
    string name;
    bit    on;
    int    idx;
    bit    chk_addr;
    int    addr;
    bit    dn;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   exp_done = 1'b0;
  logic issue = 1'b0;
  logic tag1 = 1'b0;
  logic tag2 = 1'b0;

  always @(posedge Clk) begin
    tag1 <= issue;
    tag2 <= tag1;
  end

  // Monitor: whenever a probe reaches the pipeline output, pop and compare.
  always @(negedge Clk) begin
    if (tag2) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty: output presented with no expectation queued");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (pixel_on !== e.on || int'(pixel_idx) != e.idx || done !== e.dn ||
            (e.chk_addr && int'(rom_row_addr) != e.addr)) begin
          n_fail++;
          $display("FAIL %s: got on=%0b idx=%0d addr=%0d done=%0b, want on=%0b idx=%0d addr=%0d done=%0b",
                   e.name, pixel_on, pixel_idx, rom_row_addr, done,
                   e.on, e.idx, e.chk_addr ? e.addr : -1, e.dn);
        end
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int want);
    n_tests++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic px(input string name, input int x, input int y, input bit on, input int idx,
                    input bit chk_addr, input int addr);
    exp_t e;
    e.name = name; e.on = on; e.idx = idx; e.chk_addr = chk_addr; e.addr = addr; e.dn = exp_done;
    sb.push_back(e);
    DrawX = 10'(x);
    DrawY = 10'(y);
    issue = 1'b1;
    step();
    issue = 1'b0;
    step();
    step();
  endtask

  task automatic tick();
    frame_clk = 1'b1;
    step();
    frame_clk = 1'b0;
    step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    Reset = 1'b1;
    repeat (cycles) step();
    Reset = 1'b0;
    exp_done = 1'b0;
  endtask

  initial begin
    int on_cnt;
    int done_cnt;
    step();
    do_reset(3);
    chk("rst_pixel_on", int'(pixel_on), 0);
    chk("rst_pixel_idx", int'(pixel_idx), 0);
    chk("rst_rom_addr", int'(rom_row_addr), 0);
    chk("rst_done", int'(done), 0);

    // Idle raster over the would-be box, with frame ticks.
    on_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      DrawX = 10'(142 + (i * 7) % 356);
      DrawY = 10'(i % 48);
      frame_clk = ((i % 50) < 25);
      step();
      if (pixel_on === 1'b1) on_cnt++;
      if (done === 1'b1) done_cnt++;
    end
    frame_clk = 1'b0;
    step();
    chk("idle_pixel_on_count", on_cnt, 0);
    chk("idle_done_count", done_cnt, 0);
    px("idle_probe", 142, 0, 1'b0, 0, 1'b0, 0);

    // Slide-in: y_cur tracked by the top row edge after each tick.
    pulse_start();
    px("slide_y0", 142, 0, 1'b1, 3, 1'b1, 0);
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (k == 50) exp_done = 1'b1;
      px($sformatf("slide_top_t%0d", k), 142, 4 * k, 1'b1, 3, 1'b1, 0);
      px($sformatf("slide_above_t%0d", k), 142, 4 * k - 1, 1'b0, 0, 1'b0, 0);
    end

    // Pixel mapping and box edges at rest.
    px("map_c1_r1", 146, 204, 1'b1, 1, 1'b1, 1);
    px("map_c0_r1_zero", 142, 204, 1'b0, 0, 1'b1, 1);
    px("edge_left_out", 141, 200, 1'b0, 0, 1'b0, 0);
    px("edge_last_col", 497, 200, 1'b1, 3, 1'b1, 0);
    px("edge_right_out", 498, 200, 1'b0, 0, 1'b0, 0);
    px("edge_last_row", 146, 247, 1'b1, 3, 1'b1, 11);
    px("edge_below_out", 146, 248, 1'b0, 0, 1'b0, 0);
    pulse_start();
    px("show_start_ignored", 142, 200, 1'b1, 3, 1'b1, 0);

    // Blink: hidden after 30 ticks, back after 60, y stays at 200.
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 1 || k == 29 || k == 59)
        px($sformatf("blink_t%0d", k), 142, 200, (k < 30), (k < 30) ? 3 : 0, 1'b1, 0);
      if (k == 30) px("blink_off_t30", 142, 200, 1'b0, 0, 1'b1, 0);
      if (k == 60) px("blink_on_t60", 142, 200, 1'b1, 3, 1'b1, 0);
    end

    // Reset from SHOW, then start coincident with a tick.
    do_reset(1);
    px("rst_from_show", 142, 200, 1'b0, 0, 1'b0, 0);
    start = 1'b1;
    frame_clk = 1'b1;
    step();
    start = 1'b0;
    frame_clk = 1'b0;
    step();
    px("start_tick_y0", 142, 0, 1'b1, 3, 1'b1, 0);
    tick();
    px("start_tick_y4", 142, 4, 1'b1, 3, 1'b1, 0);
    px("start_tick_y4_above", 142, 3, 1'b0, 0, 1'b0, 0);

    // Start during SLIDE is ignored.
    repeat (4) tick();
    pulse_start();
    tick();
    px("slide_start_ign_y24", 142, 24, 1'b1, 3, 1'b1, 0);
    px("slide_start_ign_y23", 142, 23, 1'b0, 0, 1'b0, 0);

    // Reset mid-SLIDE clears output within two cycles, then a restart from y=0.
    DrawX = 10'd142;
    DrawY = 10'd24;
    do_reset(1);
    step();
    chk("rst_slide_pixel_on", int'(pixel_on), 0);
    chk("rst_slide_done", int'(done), 0);
    px("rst_slide_idle", 142, 0, 1'b0, 0, 1'b0, 0);
    pulse_start();
    px("restart_y0", 142, 0, 1'b1, 3, 1'b1, 0);
    tick();
    px("restart_y4", 142, 4, 1'b1, 3, 1'b1, 0);
    px("restart_y3", 142, 3, 1'b0, 0, 1'b0, 0);

    repeat (4) step();
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
